// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI arbiter.
// Holds the FSM state enum, default sizing and SPI word field widths.
package spi_arb_pkg;

   localparam int DEF_NUM_REQ        = 2;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   localparam int SPI_WORD_W = 16;
   localparam int SPI_ADDR_W = 6;
   localparam int SPI_BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } arb_state_t;

   // Index width that stays legal for a count of one.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Arbiter <-> SPI_Controller bundle.
// Names follow the arbiter's point of view (o_ = arbiter drives).
interface spi_arbiter_if;
   import spi_arb_pkg::*;

   logic                  o_spi_go;
   logic                  o_read_write_n;
   logic [SPI_WORD_W-1:0] o_spi_data;
   logic                  i_spi_data_valid;
   logic                  i_spi_idle;
   logic [SPI_BYTE_W-1:0] i_spi_data;

   modport master (
      output o_spi_go,
      output o_read_write_n,
      output o_spi_data,
      input  i_spi_data_valid,
      input  i_spi_idle,
      input  i_spi_data
   );

   modport slave (
      input  o_spi_go,
      input  o_read_write_n,
      input  o_spi_data,
      output i_spi_data_valid,
      output i_spi_idle,
      output i_spi_data
   );

endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans from the pointer upward, wrapping, and returns a one-hot winner.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_win
);

   logic [NUM_REQ-1:0] w_win;
   logic               w_found;
   logic [IW-1:0]      w_pos;

   // First requester at or after the pointer wins.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = IW'((int'(i_ptr) + k) % NUM_REQ);
         if (!w_found && i_req[w_pos]) begin
            w_win[w_pos] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

   assign o_win = w_win;

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI_Controller among NUM_REQ masters.
// Latches the winner's word, launches it, and guards it with a timeout.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [NUM_REQ-1:0]                  i_req,
   input  logic [NUM_REQ-1:0]                  i_req_rw_n,
   input  logic [NUM_REQ-1:0][SPI_WORD_W-1:0]  i_req_data,
   output logic [NUM_REQ-1:0]                  o_gnt,
   output logic [NUM_REQ-1:0]                  o_done,
   output logic [SPI_BYTE_W-1:0]               o_rdata,
   output logic                                o_timeout,
   spi_arbiter_if.master                       spi
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int CW = idx_w(TIMEOUT_CYCLES);

   arb_state_t            r_state;
   logic [IW-1:0]         r_ptr;
   logic [IW-1:0]         r_idx;
   logic [NUM_REQ-1:0]    r_gnt;
   logic [NUM_REQ-1:0]    r_done;
   logic                  r_tmo;
   logic                  r_go;
   logic                  r_rw;
   logic [SPI_WORD_W-1:0] r_data;
   logic                  r_lat_rw;
   logic [SPI_WORD_W-1:0] r_lat_data;
   logic [SPI_BYTE_W-1:0] r_rdata;
   logic [CW-1:0]         r_cnt;

   logic [NUM_REQ-1:0]    w_win;
   logic [IW-1:0]         w_win_idx;
   logic [IW-1:0]         w_ptr_nxt;
   logic                  w_tmo_hit;
   logic                  w_rd_cap;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_win   (w_win)
   );

   // One-hot winner to binary index for the latch mux.
   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win[i]) w_win_idx = IW'(i);
      end
   end

   assign w_ptr_nxt = (r_idx == IW'(NUM_REQ - 1))
                    ? '0 : r_idx + IW'(1);
   assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   // A completing transfer wins over an expiring timeout.
   assign w_rd_cap = spi.i_spi_data_valid & r_rw
                   & (spi.i_spi_idle | ~w_tmo_hit);

   // Arbitration FSM with registered grant, launch and completion outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_idx      <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_tmo      <= 1'b0;
         r_go       <= 1'b0;
         r_rw       <= 1'b0;
         r_data     <= '0;
         r_lat_rw   <= 1'b0;
         r_lat_data <= '0;
         r_rdata    <= '0;
         r_cnt      <= '0;
      end else begin
         r_done <= '0;
         r_tmo  <= 1'b0;
         r_go   <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (|i_req) begin
                  r_gnt      <= w_win;
                  r_idx      <= w_win_idx;
                  r_lat_rw   <= i_req_rw_n[w_win_idx];
                  r_lat_data <= i_req_data[w_win_idx];
                  r_state    <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_go    <= 1'b1;
               r_rw    <= r_lat_rw;
               r_data  <= r_lat_data;
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (w_tmo_hit) begin
                  r_done  <= r_gnt;
                  r_tmo   <= 1'b1;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  if (!spi.i_spi_idle) r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (w_rd_cap) r_rdata <= spi.i_spi_data;
               if (spi.i_spi_idle) begin
                  r_done  <= r_gnt;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_IDLE;
               end else if (w_tmo_hit) begin
                  r_done  <= r_gnt;
                  r_tmo   <= 1'b1;
                  r_gnt   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_gnt              = r_gnt;
   assign o_done             = r_done;
   assign o_timeout          = r_tmo;
   assign o_rdata            = r_rdata;
   assign spi.o_spi_go       = r_go;
   assign spi.o_read_write_n = r_rw;
   assign spi.o_spi_data     = r_data;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one SPI_Controller.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum i_clk cycles from launch to transfer completion.
REQ-003 i_clk  in  1  system clock; one clock; all logic on its rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  NUM_REQ  per-requester transaction request, level.
REQ-006 i_req_rw_n  in  NUM_REQ  per-requester direction: 1 = read, 0 = write.
REQ-007 i_req_data  in  NUM_REQ x 16  per-requester SPI word {R/W, MB, addr[5:0], wdata[7:0]}.
REQ-008 o_gnt  out  NUM_REQ  one-hot grant; held for the whole transaction.
REQ-009 o_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-010 o_rdata  out  8  read byte from the last completed read; held until the next read completes.
REQ-011 o_timeout  out  1  one-cycle pulse, coincident with o_done, when a transaction is aborted.
REQ-012 o_spi_go / o_read_write_n / o_spi_data[15:0]  out  to SPI_Controller i_spi_go / i_read_write_n / i_data.
REQ-013 i_spi_data_valid / i_spi_idle / i_spi_data[7:0]  in  from SPI_Controller o_data_valid / o_idle / o_data.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: when i_req is nonzero, select a winner, register o_gnt one-hot, latch that requester's i_req_rw_n and i_req_data, and go to LAUNCH; otherwise stay.
REQ-016 Round-robin selection: the search starts at the priority pointer and wraps modulo NUM_REQ; after a transaction the pointer moves to (served index + 1) mod NUM_REQ, including on timeout.
REQ-017 Simultaneous requests: only the pointer-favoured requester is granted; the others wait, with no request lost or reordered.
REQ-018 LAUNCH: o_spi_go = 1 for exactly one cycle with the latched o_spi_data and o_read_write_n; go to WAIT_BUSY. Latency: request seen in IDLE at cycle N -> o_gnt at N+1, o_spi_go at N+2.
REQ-019 WAIT_BUSY: go to WAIT_DONE on i_spi_idle = 0.
REQ-020 WAIT_DONE: on i_spi_data_valid during a read, register i_spi_data into o_rdata. On i_spi_idle = 1, pulse o_done[winner], clear o_gnt in the same cycle, and return to IDLE.
REQ-021 o_spi_data and o_read_write_n hold their latched values from LAUNCH until the next LAUNCH.
REQ-022 Changes on i_req_data / i_req_rw_n after the grant have no effect on the transaction in progress.
REQ-023 Deassertion of the granted i_req mid-transaction does not abort it; o_done is still issued.
REQ-024 A requester that keeps i_req high after o_done is treated as a new request and arbitrated fairly in IDLE.
REQ-025 Timeout counter: cleared in LAUNCH, increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES-1: pulse o_done[winner] and o_timeout, clear o_gnt, leave o_rdata unchanged, return to IDLE.
REQ-026 i_spi_data_valid outside WAIT_DONE, or during a write, is ignored.

Reset
REQ-027 While i_rst_n = 0 at a clock edge: state = IDLE, pointer = 0, o_gnt = 0, o_done = 0, o_timeout = 0, o_spi_go = 0, o_read_write_n = 0, o_spi_data = 0, o_rdata = 0, timeout counter = 0.
REQ-028 Reset asserted mid-transaction takes effect at the next edge and issues no o_done.
REQ-029 After reset the SPI_Controller is not re-driven until a new request arrives.

Structure
REQ-030 A shared package spi_arb_pkg holds the FSM state enum, the default NUM_REQ and TIMEOUT_CYCLES, and the SPI word field widths.
REQ-031 Combinational round-robin pick is a sub-module rr_pick (inputs: request vector and pointer; output: one-hot winner); the FSM, latches and counter stay in spi_arbiter.

Verification
REQ-032 Single write: i_req[0] = 1 with data 16'h2D08 -> o_gnt = 2'b01; o_spi_go for one cycle carrying 16'h2D08; o_done[0] pulses one cycle after i_spi_idle rises.
REQ-033 Contention: i_req = 2'b11 in the same cycle after reset -> requester 0 served first, then requester 1; the grant order repeats 0,1,0,1 with both requests held high.
REQ-034 Read: requester 1 issues 16'hB200 with rw_n = 1; the model returns 8'hA5 on data_valid -> o_rdata = 8'hA5 at o_done[1], and is held through a following write.
REQ-035 Timeout: the model never drops i_spi_idle, with TIMEOUT_CYCLES = 16 -> o_timeout and o_done pulse 16 cycles after launch, the pointer advances, and the next request is served normally.
REQ-036 Reset mid-transfer in WAIT_DONE -> all outputs reach their REQ-027 values at the next edge, with no o_done pulse.
REQ-037 Data stability: i_req_data[0] changes from 16'h2C05 to 16'hFFFF after the grant -> o_spi_data stays 16'h2C05.
